// File: rtl/lw_hmac_key_loader.sv
// lw_hmac_key_loader
//   Host-facing HMAC key staging buffer feeding the HMAC core key port.
//   The host writes 1..KEY_WORDS words and commits. The block zero-pads the
//   rest of the block, raises new_key_o, and then streams KEY_WORDS words over a
//   key_valid_o/key_ready_i handshake. Words go out in write order, word 0 first.
//   Optional build macro: KEY_ZEROIZE_EN. When it is defined, the buffer is wiped
//   on abort_i. It is also wiped during one extra cycle after the last beat, and
//   fill_ready_o stays low for that cycle.
module lw_hmac_key_loader #(
  parameter int WORD_W    = 64,
  parameter int KEY_WORDS = 16
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              key_wr_i,
  input  logic [WORD_W-1:0] key_data_i,
  input  logic              key_commit_i,
  input  logic              abort_i,
  input  logic              key_ready_i,
  output logic [WORD_W-1:0] key_o,
  output logic              key_valid_o,
  output logic              new_key_o,
  output logic              fill_ready_o,
  output logic              key_done_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(KEY_WORDS);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_STREAM,
    S_WIPE
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [WORD_W-1:0] key_buf [KEY_WORDS];

  logic              fill_phase;
  logic              wr_full;
  logic              wr_take;
  logic              commit_take;
  logic              err_set;
  logic              wipe;
  logic [CNT_W-1:0]  pad_base;
  logic [PTR_W-1:0]  rd_ptr_next;

  // The host may only write or commit while the buffer is not owned by the core.
  assign fill_phase  = (state_reg == S_IDLE) || (state_reg == S_FILL);
  assign wr_full     = (wr_ptr_reg == CNT_W'(KEY_WORDS));
  assign wr_take     = key_wr_i && fill_phase && !wr_full && !abort_i;
  assign commit_take = key_commit_i && fill_phase && !abort_i;
  // A write in the commit cycle lands first, so padding starts one slot later.
  assign pad_base    = wr_ptr_reg + CNT_W'(wr_take);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(1);
  // Overflowing write, or any host access while the core owns the buffer.
  assign err_set     = ((key_wr_i || key_commit_i) && !fill_phase) ||
                       (key_wr_i && fill_phase && wr_full);

`ifdef KEY_ZEROIZE_EN
  assign wipe = abort_i || (state_reg == S_WIPE);
`else
  assign wipe = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_buf
      // One key word: takes a host write at its slot, or zero padding at commit.
      always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
          key_buf[gi] <= '0;
        end else if (wipe) begin
          key_buf[gi] <= '0;
        end else if (wr_take && (wr_ptr_reg == CNT_W'(gi))) begin
          key_buf[gi] <= key_data_i;
        end else if (commit_take && (pad_base <= CNT_W'(gi))) begin
          key_buf[gi] <= '0;
        end
      end
    end
  endgenerate

  // Control FSM. All outputs are registered. key_o is preloaded one word ahead
  // so that accepted beats follow each other with no bubbles.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_reg    <= S_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      key_o        <= '0;
      key_valid_o  <= 1'b0;
      new_key_o    <= 1'b0;
      fill_ready_o <= 1'b1;
      key_done_o   <= 1'b0;
      err_o        <= 1'b0;
    end else if (abort_i) begin
      state_reg    <= S_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      key_o        <= '0;
      key_valid_o  <= 1'b0;
      new_key_o    <= 1'b0;
      fill_ready_o <= 1'b1;
      key_done_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      key_done_o <= 1'b0;
      if (err_set) begin
        err_o <= 1'b1;
      end
      if (wr_take) begin
        wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
      end
      case (state_reg)
        S_IDLE, S_FILL: begin
          if (commit_take) begin
            state_reg    <= S_ARMED;
            new_key_o    <= 1'b1;
            fill_ready_o <= 1'b0;
          end else if (wr_take) begin
            state_reg <= S_FILL;
          end
        end
        S_ARMED: begin
          if (key_ready_i) begin
            state_reg   <= S_STREAM;
            key_valid_o <= 1'b1;
            key_o       <= key_buf[0];
          end
        end
        S_STREAM: begin
          if (key_ready_i) begin
            if (rd_ptr_reg == PTR_W'(KEY_WORDS - 1)) begin
              key_valid_o <= 1'b0;
              key_o       <= '0;
              new_key_o   <= 1'b0;
              key_done_o  <= 1'b1;
              rd_ptr_reg  <= '0;
              wr_ptr_reg  <= '0;
`ifdef KEY_ZEROIZE_EN
              state_reg   <= S_WIPE;
`else
              state_reg    <= S_IDLE;
              fill_ready_o <= 1'b1;
`endif
            end else begin
              rd_ptr_reg <= rd_ptr_next;
              key_o      <= key_buf[rd_ptr_next];
            end
          end
        end
        S_WIPE: begin
          state_reg    <= S_IDLE;
          fill_ready_o <= 1'b1;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
